demultiplexer_1to8_buf: RTL and testbench
=========================================

Name: demultiplexer_1to8_buf

Overview:
- Buffered 1-to-8 distributor: the counterpart of the 8-to-1 operand multiplexer in the ALU datapath.
- Takes one IN_WIDTH-bit word with a 3-bit destination select over a valid/ready handshake and steers it into one of eight registered output channels.
- Each output channel has its own valid/ready handshake.
- Used to route ALU results to per-consumer writeback lanes.

Parameters:
- IN_WIDTH, 32, data word width in bits.
- CNT_WIDTH, 16, width of per-channel transfer counters (used only with DEMUX_STAT_EN).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input word present.
- in_ready  output  1  block accepts input word this cycle.
- in_data  input  IN_WIDTH  input word.
- in_sel  input  3  destination channel 0..7.
- out_valid  output  8  bit i: channel i holds a word.
- out_ready  input  8  bit i: consumer i takes the word this cycle.
- out_data  output  8*IN_WIDTH  channel i word at bits [i*IN_WIDTH +: IN_WIDTH].
- stat_sel  input  3  counter read select (DEMUX_STAT_EN only).
- stat_cnt  output  CNT_WIDTH  counter read data (DEMUX_STAT_EN only).

Behaviour:
- Reset (async assert, sync release on clk): out_valid = 0, all out_data = 0, counters = 0. in_ready reads 0 while rst_n is low.
- Each channel is a one-entry slot with states EMPTY and FULL.
  - EMPTY -> FULL on write.
  - FULL -> EMPTY on drain without a write.
  - FULL -> FULL on drain and write in the same cycle; the new word replaces the old one.
  - FULL stays FULL while held.
- Drain on channel i: out_valid[i] & out_ready[i].
- in_ready = !out_valid[in_sel] | out_ready[in_sel]. This is combinational from in_sel, out_valid and out_ready, and is independent of in_valid.
- Accept: in_valid & in_ready. On accept, in_data is written into slot in_sel, and out_valid[in_sel] is 1 on the next cycle.
- Latency: 1 cycle from input accept to out_valid. Sustained throughput of 1 word/cycle per channel when the consumer keeps out_ready high.
- At most one slot is written per cycle. Other channels may drain concurrently and independently.
- Stall: a full slot with out_ready low holds its data and valid stable. The input stalls only if it targets that slot; a word for a different channel is accepted.
- out_data[i] changes only on a write to slot i. The value is undefined-free, i.e. it keeps the last written word after a drain.
- in_sel is sampled only on accept. When in_valid is low, in_sel and in_data are don't-care.
- Reset mid-transfer drops all buffered words. No partial state survives.
- No combinational path from in_data to out_data.

Optional Feature:
- Macro: DEMUX_STAT_EN.
- Defined:
  - Eight CNT_WIDTH-bit counters; counter i increments on each accept with in_sel == i.
  - Counters saturate at all-ones and never wrap.
  - stat_cnt = counter[stat_sel], combinational.
- Undefined:
  - No counters are built.
  - stat_cnt is tied to 0; stat_sel is ignored.
  - Port list is unchanged.

Decomposition:
- Package demux_pkg:
  - DEMUX_NUM_OUT = 8 and DEMUX_SEL_W = 3.
  - Typedef demux_sel_t = logic [DEMUX_SEL_W-1:0].
  - Shared with the 8-to-1 mux select encoding: 3'b000 = lane 0 … 3'b111 = lane 7.
- Sub-module demux_out_slot:
  - One-entry register slice with wr_en, wr_data, rd_ready, valid and data.
  - Instantiated 8 times in a generate loop.
  - Top level holds the select decode, the in_ready mux and the optional counters.

Test Plan:
- Reset: hold rst_n = 0 with in_valid = 1 → out_valid = 8'h00, in_ready = 0, all out_data = 0. Release reset → first accept is visible one cycle later.
- Single route: in_data = 32'hDEADBEEF, in_sel = 5, out_ready = 8'hFF → next cycle out_valid = 8'h20 and out_data[5] = 32'hDEADBEEF. The cycle after, out_valid = 0.
- Backpressure: out_ready = 0. Send 32'h1 to ch 2 (accepted), then 32'h2 to ch 2 → in_ready = 0 and ch 2 holds 32'h1. Raise out_ready[2] → 32'h1 drains and 32'h2 is accepted the same cycle, appearing the next cycle.
- Non-blocking: ch 2 full and stalled; send 32'hA5 to ch 7 → accepted, with out_valid = 8'h84 next cycle.
- Streaming: 16 consecutive words to ch 0 with out_ready[0] = 1 → in_ready stays 1 throughout, and the words emerge in order one per cycle with 1-cycle latency.
- DEMUX_STAT_EN: send 3 words to ch 1 and 1 word to ch 6; stat_sel = 1 → stat_cnt = 3, stat_sel = 6 → 1. Force counter 1 to all-ones and accept one more → counter stays all-ones. Without the macro, stat_cnt = 0.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared select encoding and slot state for the 1-to-8 result distributor.
// Select code n addresses lane n, matching the 8-to-1 operand mux encoding.
// No logic of its own; types, constants and a one-hot decode helper only.
package demux_pkg;

   localparam int DEMUX_NUM_OUT = 8;
   localparam int DEMUX_SEL_W   = 3;

   typedef logic [DEMUX_SEL_W-1:0] demux_sel_t;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_e;

   // Decode a lane select into a one-hot write strobe vector.
   function automatic logic [DEMUX_NUM_OUT-1:0] demux_onehot(input demux_sel_t sel);
      logic [DEMUX_NUM_OUT-1:0] oh;
      oh      = '0;
      oh[sel] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/demux_out_slot.sv
// One-entry registered output slot (EMPTY/FULL) for one distributor lane.
// Latency: a write is visible on valid/data the following cycle.
// Backpressure: holds word while rd_ready is low; drain+write in one cycle replaces the word.
module demux_out_slot
   import demux_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         wr_en,
   input  logic [W-1:0] wr_data,
   input  logic         rd_ready,
   output logic         valid,
   output logic [W-1:0] data
);

   slot_state_e  state_q, state_d;
   logic [W-1:0] data_q, data_d;

   // State and payload registers; reset empties the slot and clears the word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SLOT_EMPTY;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
      end
   end

   // Next state: a write always leaves the slot full; a drain alone empties it.
   // Payload only changes on a write, so the last word stays readable after a drain.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      case (state_q)
         SLOT_EMPTY: if (wr_en) state_d = SLOT_FULL;
         SLOT_FULL:  if (rd_ready && !wr_en) state_d = SLOT_EMPTY;
      endcase
      if (wr_en) data_d = wr_data;
   end

   // Outputs come straight from the registers, so there is no data feed-through.
   always_comb begin
      valid = (state_q == SLOT_FULL);
      data  = data_q;
   end

endmodule

// File: rtl/demultiplexer_1to8_buf.sv
// Buffered 1-to-8 distributor steering ALU results to per-consumer writeback lanes.
// Latency: 1 cycle from input accept to out_valid; 1 word/cycle per lane sustained.
// Backpressure: input stalls only when its target lane is full and not draining. Option: DEMUX_STAT_EN.
module demultiplexer_1to8_buf
   import demux_pkg::*;
#(
   parameter int IN_WIDTH  = 32,
   parameter int CNT_WIDTH = 16
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [IN_WIDTH-1:0]               in_data,
   input  demux_sel_t                        in_sel,
   output logic [DEMUX_NUM_OUT-1:0]          out_valid,
   input  logic [DEMUX_NUM_OUT-1:0]          out_ready,
   output logic [DEMUX_NUM_OUT*IN_WIDTH-1:0] out_data,
   input  demux_sel_t                        stat_sel,
   output logic [CNT_WIDTH-1:0]              stat_cnt
);

   logic                     accept;
   logic [DEMUX_NUM_OUT-1:0] wr_en;

   // Ready looks only at the addressed lane so other full lanes never block it;
   // held low during reset so nothing is offered as accepted.
   always_comb begin
      in_ready = rst_n & (!out_valid[in_sel] | out_ready[in_sel]);
      accept   = in_valid & in_ready;
      wr_en    = accept ? demux_onehot(in_sel) : '0;
   end

   for (genvar g = 0; g < DEMUX_NUM_OUT; g++) begin : g_slot
      demux_out_slot #(.W(IN_WIDTH)) u_slot (
         .clk      (clk),
         .rst_n    (rst_n),
         .wr_en    (wr_en[g]),
         .wr_data  (in_data),
         .rd_ready (out_ready[g]),
         .valid    (out_valid[g]),
         .data     (out_data[g*IN_WIDTH +: IN_WIDTH])
      );
   end

`ifdef DEMUX_STAT_EN
   logic [CNT_WIDTH-1:0] cnt_q [DEMUX_NUM_OUT];
   logic [CNT_WIDTH-1:0] cnt_d [DEMUX_NUM_OUT];

   // Per-lane accept counters, saturating at all-ones instead of wrapping.
   always_comb begin
      for (int i = 0; i < DEMUX_NUM_OUT; i++) begin
         cnt_d[i] = cnt_q[i];
         if (wr_en[i] && (cnt_q[i] != '1)) cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
      end
   end

   // Counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEMUX_NUM_OUT; i++) cnt_q[i] <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign stat_cnt = cnt_q[stat_sel];
`else
   // No counters built: read port returns zero and the select is ignored.
   logic stat_sel_unused;
   assign stat_sel_unused = ^stat_sel;
   assign stat_cnt        = '0;
`endif

endmodule

// File: tb/tb_demultiplexer_1to8_buf.sv
module tb_demultiplexer_1to8_buf;

   localparam int W  = 32;
   localparam int CW = 4;

   logic           clk;
   logic           rst_n;
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   in_data;
   logic [2:0]     in_sel;
   logic [7:0]     out_valid;
   logic [7:0]     out_ready;
   logic [8*W-1:0] out_data;
   logic [2:0]     stat_sel;
   logic [CW-1:0]  stat_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   demultiplexer_1to8_buf #(.IN_WIDTH(W), .CNT_WIDTH(CW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .stat_sel  (stat_sel),
      .stat_cnt  (stat_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [W-1:0] lane(input int ch);
      return out_data[ch*W +: W];
   endfunction

   // Drive one accepted-or-not word for a cycle, then idle; called just after a negedge.
   task automatic send(input logic [2:0] s, input logic [W-1:0] d, input logic [7:0] r);
      in_valid  = 1'b1;
      in_sel    = s;
      in_data   = d;
      out_ready = r;
      @(posedge clk);
      @(negedge clk);
      in_valid  = 1'b0;
   endtask

   typedef struct {
      logic       vld;
      logic [2:0] sel;
      logic [W-1:0] dat;
      logic [7:0] ordy;
      logic       exp_rdy;
      logic [7:0] exp_ovld;
      logic [2:0] chk_ch;
      logic [W-1:0] exp_dat;
   } vec_t;

   vec_t vecs [9];

   initial begin
      //             vld  sel   dat           ordy   rdy   ovld   ch    data after edge
      vecs[0] = '{1'b1, 3'd5, 32'hDEADBEEF, 8'hFF, 1'b1, 8'h20, 3'd5, 32'hDEADBEEF};
      vecs[1] = '{1'b0, 3'd0, 32'h0,        8'hFF, 1'b1, 8'h00, 3'd5, 32'hDEADBEEF};
      vecs[2] = '{1'b1, 3'd2, 32'h1,        8'h00, 1'b1, 8'h04, 3'd2, 32'h1};
      vecs[3] = '{1'b1, 3'd2, 32'h2,        8'h00, 1'b0, 8'h04, 3'd2, 32'h1};
      vecs[4] = '{1'b1, 3'd7, 32'hA5,       8'h00, 1'b1, 8'h84, 3'd7, 32'hA5};
      vecs[5] = '{1'b1, 3'd2, 32'h2,        8'h04, 1'b1, 8'h84, 3'd2, 32'h2};
      vecs[6] = '{1'b0, 3'd2, 32'h0,        8'h00, 1'b0, 8'h84, 3'd2, 32'h2};
      vecs[7] = '{1'b1, 3'd7, 32'hB6,       8'h80, 1'b1, 8'h84, 3'd7, 32'hB6};
      vecs[8] = '{1'b0, 3'd0, 32'h0,        8'hFF, 1'b1, 8'h00, 3'd7, 32'hB6};

      rst_n     = 1'b0;
      in_valid  = 1'b1;
      in_sel    = 3'd5;
      in_data   = 32'hDEADBEEF;
      out_ready = 8'hFF;
      stat_sel  = 3'd0;

      // Reset state with a word offered
      @(posedge clk);
      #1;
      chk("rst_in_ready", {31'b0, in_ready}, 32'h0);
      chk("rst_out_valid", {24'b0, out_valid}, 32'h0);
      for (int i = 0; i < 8; i++) chk($sformatf("rst_out_data%0d", i), lane(i), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Table-driven route / stall / non-blocking / drain+write sequence
      for (int v = 0; v < 9; v++) begin
         in_valid  = vecs[v].vld;
         in_sel    = vecs[v].sel;
         in_data   = vecs[v].dat;
         out_ready = vecs[v].ordy;
         #1;
         chk($sformatf("vec%0d_in_ready", v), {31'b0, in_ready}, {31'b0, vecs[v].exp_rdy});
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_out_valid", v), {24'b0, out_valid}, {24'b0, vecs[v].exp_ovld});
         chk($sformatf("vec%0d_out_data", v), lane(int'(vecs[v].chk_ch)), vecs[v].exp_dat);
         @(negedge clk);
      end

      // Streaming 16 words into lane 0 with the consumer always ready
      for (int i = 0; i < 16; i++) begin
         in_valid  = 1'b1;
         in_sel    = 3'd0;
         in_data   = 32'h100 + i;
         out_ready = 8'h01;
         #1;
         chk($sformatf("stream%0d_in_ready", i), {31'b0, in_ready}, 32'h1);
         @(posedge clk);
         #1;
         chk($sformatf("stream%0d_valid", i), {24'b0, out_valid}, 32'h01);
         chk($sformatf("stream%0d_data", i), lane(0), 32'h100 + i);
         @(negedge clk);
      end
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("stream_end_valid", {24'b0, out_valid}, 32'h0);
      @(negedge clk);

      // Reset in the middle of a buffered transfer drops everything
      in_valid  = 1'b1;
      in_sel    = 3'd3;
      in_data   = 32'h33;
      out_ready = 8'h00;
      @(posedge clk);
      #1;
      chk("midrst_loaded", {24'b0, out_valid}, 32'h08);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", {24'b0, out_valid}, 32'h0);
      chk("midrst_out_data3", lane(3), 32'h0);
      chk("midrst_in_ready", {31'b0, in_ready}, 32'h0);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b1;

      // Counter traffic: 3 words to lane 1, 1 word to lane 6
      send(3'd1, 32'h11, 8'hFF);
      send(3'd1, 32'h12, 8'hFF);
      send(3'd1, 32'h13, 8'hFF);
      send(3'd6, 32'h61, 8'hFF);
`ifdef DEMUX_STAT_EN
      stat_sel = 3'd1;
      #1;
      chk("stat_cnt1", {28'b0, stat_cnt}, 32'd3);
      stat_sel = 3'd6;
      #1;
      chk("stat_cnt6", {28'b0, stat_cnt}, 32'd1);
      stat_sel = 3'd0;
      #1;
      chk("stat_cnt0", {28'b0, stat_cnt}, 32'd0);
      @(negedge clk);
      for (int i = 0; i < 12; i++) send(3'd1, 32'h20 + i, 8'hFF);
      stat_sel = 3'd1;
      #1;
      chk("stat_cnt1_full", {28'b0, stat_cnt}, 32'd15);
      @(negedge clk);
      send(3'd1, 32'h99, 8'hFF);
      #1;
      chk("stat_cnt1_sat", {28'b0, stat_cnt}, 32'd15);
`else
      stat_sel = 3'd1;
      #1;
      chk("stat_off_cnt1", {28'b0, stat_cnt}, 32'd0);
      stat_sel = 3'd6;
      #1;
      chk("stat_off_cnt6", {28'b0, stat_cnt}, 32'd0);
`endif
      @(negedge clk);
      chk("final_out_valid", {24'b0, out_valid}, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
